// File: rtl/memory_cell_arbiter.sv
// memory_cell_arbiter: two-client port-A arbiter plus port-B burst reader for one memory_cell RAM.
// Define MC_ARB_RR_EN for round-robin contention; otherwise client 0 has fixed priority.
module memory_cell_arbiter #(
  parameter int ADDR     = 12,
  parameter int WIDTH    = 32,
  parameter int NUM      = 53,
  parameter int TIMESTEP = 1,
  parameter int TSW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a0_req,
  input  logic             a0_we,
  input  logic [TSW-1:0]   a0_ts,
  input  logic [ADDR-1:0]  a0_idx,
  input  logic [WIDTH-1:0] a0_wdata,
  output logic             a0_gnt,
  output logic             a0_rvalid,
  input  logic             a1_req,
  input  logic             a1_we,
  input  logic [TSW-1:0]   a1_ts,
  input  logic [ADDR-1:0]  a1_idx,
  input  logic [WIDTH-1:0] a1_wdata,
  output logic             a1_gnt,
  output logic             a1_rvalid,
  output logic             a_err,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_start,
  input  logic [TSW-1:0]   b_ts,
  output logic             b_busy,
  output logic             b_valid,
  output logic [ADDR-1:0]  b_idx,
  output logic [WIDTH-1:0] b_data,
  output logic             b_done,
  output logic             mem_wr_a,
  output logic [ADDR-1:0]  mem_addr_a,
  output logic [WIDTH-1:0] mem_i_a,
  output logic [ADDR-1:0]  mem_addr_b,
  input  logic [WIDTH-1:0] mem_o_a,
  input  logic [WIDTH-1:0] mem_o_b
);
  localparam int PW = ADDR + TSW;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
  state_t           state_q;
  logic [ADDR-1:0]  cnt_q, base_q, b_idx_q;
  logic             b_valid_q, b_done_q, rv0_q, rv1_q;
  logic             rr_pick, any, sel, we_a, ok_a, b_ok;
  logic [TSW-1:0]   ts_a;
  logic [ADDR-1:0]  idx_a;
  logic [PW-1:0]    full_a, full_b;
`ifdef MC_ARB_RR_EN
  logic last_q;
  assign rr_pick = ~last_q;
  always_ff @(posedge clk)
    if (rst) last_q <= 1'b1;
    else if (any) last_q <= sel;
`else
  assign rr_pick = 1'b0;
`endif
  // with idx < NUM, the flat address is in range exactly when ts < TIMESTEP
  always_comb begin
    any        = a0_req | a1_req;
    sel        = a1_req & (~a0_req | rr_pick);
    ts_a       = sel ? a1_ts : a0_ts;
    idx_a      = sel ? a1_idx : a0_idx;
    we_a       = sel ? a1_we : a0_we;
    mem_i_a    = sel ? a1_wdata : a0_wdata;
    full_a     = PW'(ts_a) * PW'(NUM) + PW'(idx_a);
    ok_a       = (PW'(idx_a) < PW'(NUM)) && (full_a < PW'(TIMESTEP * NUM));
    a0_gnt     = any & ~sel;
    a1_gnt     = sel;
    a_err      = any & ~ok_a;
    mem_wr_a   = any & we_a & ok_a;
    mem_addr_a = (any & ok_a) ? full_a[ADDR-1:0] : '0;
    full_b     = PW'(b_ts) * PW'(NUM);
    b_ok       = full_b < PW'(TIMESTEP * NUM);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      b_idx_q   <= '0;
      b_valid_q <= 1'b0;
      b_done_q  <= 1'b0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
    end else begin
      rv0_q     <= a0_gnt & ~a0_we;
      rv1_q     <= a1_gnt & ~a1_we;
      b_valid_q <= state_q == BURST;
      b_idx_q   <= cnt_q;
      b_done_q  <= (state_q == BURST && cnt_q == ADDR'(NUM - 1)) ||
                   (state_q == IDLE && b_start && !b_ok);
      case (state_q)
        IDLE: if (b_start && b_ok) begin
          state_q <= BURST;
          cnt_q   <= '0;
          base_q  <= full_b[ADDR-1:0];
        end
        BURST: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == ADDR'(NUM - 1)) state_q <= DRAIN;
        end
        DRAIN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign a0_rvalid  = rv0_q;
  assign a1_rvalid  = rv1_q;
  assign a_rdata    = mem_o_a;
  assign b_busy     = state_q != IDLE;
  assign b_valid    = b_valid_q;
  assign b_idx      = b_idx_q;
  assign b_data     = mem_o_b;
  assign b_done     = b_done_q;
  assign mem_addr_b = base_q + cnt_q;
endmodule

// File: tb/tb_memory_cell_arbiter.sv
// tb_memory_cell_arbiter: directed and random checks of memory_cell_arbiter against a RAM model and scoreboard.
module tb_memory_cell_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        a0_req = 0, a0_we = 0, a1_req = 0, a1_we = 0, b_start = 0;
  logic [3:0]  a0_ts = 0, a1_ts = 0, b_ts = 0;
  logic [11:0] a0_idx = 0, a1_idx = 0;
  logic [31:0] a0_wdata = 0, a1_wdata = 0;
  logic        a0_gnt, a1_gnt, a0_rvalid, a1_rvalid, a_err, b_busy, b_valid, b_done, mem_wr_a;
  logic [31:0] a_rdata, b_data, mem_i_a, mem_o_a, mem_o_b;
  logic [11:0] b_idx, mem_addr_a, mem_addr_b;
  logic [31:0] ram [0:4095];
  logic [31:0] golden [0:52];
  int          n_cmp = 0, n_bad = 0;
  logic        last = 1'b1, exp_rv0 = 0, exp_rv1 = 0;
  logic [31:0] exp_rd = 0;

  memory_cell_arbiter dut (
    .clk(clk), .rst(rst),
    .a0_req(a0_req), .a0_we(a0_we), .a0_ts(a0_ts), .a0_idx(a0_idx), .a0_wdata(a0_wdata),
    .a0_gnt(a0_gnt), .a0_rvalid(a0_rvalid),
    .a1_req(a1_req), .a1_we(a1_we), .a1_ts(a1_ts), .a1_idx(a1_idx), .a1_wdata(a1_wdata),
    .a1_gnt(a1_gnt), .a1_rvalid(a1_rvalid),
    .a_err(a_err), .a_rdata(a_rdata),
    .b_start(b_start), .b_ts(b_ts), .b_busy(b_busy), .b_valid(b_valid), .b_idx(b_idx),
    .b_data(b_data), .b_done(b_done),
    .mem_wr_a(mem_wr_a), .mem_addr_a(mem_addr_a), .mem_i_a(mem_i_a), .mem_addr_b(mem_addr_b),
    .mem_o_a(mem_o_a), .mem_o_b(mem_o_b)
  );

  always #5 clk = ~clk;

  // memory_cell stand-in: registered reads, read-before-write
  always @(posedge clk) begin
    if (mem_wr_a) ram[mem_addr_a] <= mem_i_a;
    mem_o_a <= ram[mem_addr_a];
    mem_o_b <= ram[mem_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // returns 1 when client 1 should win
  function automatic logic pick(input logic r0, input logic r1);
`ifdef MC_ARB_RR_EN
    return r1 && (!r0 || last == 1'b0);
`else
    return r1 && !r0;
`endif
  endfunction

  task automatic acyc(input logic r0, input logic w0, input logic [3:0] t0, input logic [11:0] x0,
                      input logic [31:0] d0, input logic r1, input logic w1, input logic [3:0] t1,
                      input logic [11:0] x1, input logic [31:0] d1);
    logic s, we, ok, any;
    logic [3:0] t;
    logic [11:0] x;
    logic [31:0] d;
    @(negedge clk);
    chk("a0_rvalid", a0_rvalid, exp_rv0);
    chk("a1_rvalid", a1_rvalid, exp_rv1);
    if (exp_rv0 || exp_rv1) chk("a_rdata", a_rdata, exp_rd);
    a0_req = r0; a0_we = w0; a0_ts = t0; a0_idx = x0; a0_wdata = d0;
    a1_req = r1; a1_we = w1; a1_ts = t1; a1_idx = x1; a1_wdata = d1;
    #1;
    any = r0 || r1;
    s   = pick(r0, r1);
    t   = s ? t1 : t0;
    x   = s ? x1 : x0;
    we  = s ? w1 : w0;
    d   = s ? d1 : d0;
    ok  = (int'(t) < 1) && (int'(x) < 53);
    chk("a0_gnt", a0_gnt, any && !s);
    chk("a1_gnt", a1_gnt, s);
    if (any) begin
      chk("a_err", a_err, !ok);
      chk("mem_wr_a", mem_wr_a, we && ok);
      chk("mem_addr_a", mem_addr_a, ok ? 12'(int'(t) * 53 + int'(x)) : 12'd0);
      if (we) chk("mem_i_a", mem_i_a, d);
    end else chk("mem_wr_a_idle", mem_wr_a, 1'b0);
    exp_rv0 = r0 && !s && !w0;
    exp_rv1 = s && !w1;
    exp_rd  = golden[0];
    if (ok) exp_rd = golden[x];
    if (any && we && ok) golden[x] = d;
    if (any) last = s;
  endtask

  task automatic idle();
    acyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int nv;
    logic seen;
    repeat (2) @(negedge clk);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_done", b_done, 0);
    chk("rst_a0_rvalid", a0_rvalid, 0);
    chk("rst_a1_rvalid", a1_rvalid, 0);
    chk("rst_a0_gnt", a0_gnt, 0);
    rst = 0;
    for (int i = 0; i < 53; i++)
      acyc(1, 1, 0, 12'(i), (i == 5) ? 32'hDEAD : $urandom, 0, 0, 0, 0, 0);
    acyc(0, 0, 0, 0, 0, 1, 0, 0, 5, 0);
    idle();
    chk("rd_deadbeef", golden[5], 32'hDEAD);
    repeat (4) acyc(1, 0, 0, 12'($urandom_range(0, 52)), 0, 1, 0, 0, 12'($urandom_range(0, 52)), 0);
    idle();
    acyc(1, 1, 0, 53, 32'hBAD0BAD0, 0, 0, 0, 0, 0);
    acyc(0, 0, 0, 0, 0, 1, 0, 1, 3, 0);
    acyc(1, 0, 0, 53, 0, 0, 0, 0, 0, 0);
    idle();
    repeat (300)
      acyc($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 5) == 0) ? 4'd1 : 4'd0,
           12'($urandom_range(0, 56)), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 5) == 0) ? 4'd1 : 4'd0,
           12'($urandom_range(0, 56)), $urandom);
    idle();
    // full burst with restart attempts mid-burst and in the drain cycle
    @(negedge clk);
    b_start = 1; b_ts = 0;
    nv = 0;
    for (int k = 1; k <= 58; k++) begin
      @(negedge clk);
      b_start = (k == 20 || k == 54);
      chk("b_busy", b_busy, k <= 54);
      chk("b_valid", b_valid, k >= 2 && k <= 54);
      chk("b_done", b_done, k == 54);
      if (b_valid) begin
        nv++;
        chk("b_idx", b_idx, 12'(k - 2));
        chk("b_data", b_data, golden[k-2]);
      end
    end
    chk("b_count", nv, 53);
    @(negedge clk);
    b_start = 1; b_ts = 1;
    @(negedge clk);
    b_start = 0; b_ts = 0;
    chk("bad_ts_done", b_done, 1);
    chk("bad_ts_valid", b_valid, 0);
    chk("bad_ts_busy", b_busy, 0);
    @(negedge clk);
    chk("bad_ts_done_clr", b_done, 0);
    // reset while the burst counter sits at 10, with a read in flight
    b_start = 1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      b_start = 0;
    end
    chk("pre_rst_busy", b_busy, 1);
    rst = 1; a0_req = 1; a0_we = 0; a0_ts = 0; a0_idx = 7;
    @(negedge clk);
    rst = 0; a0_req = 0;
    last = 1; exp_rv0 = 0; exp_rv1 = 0;
    chk("mid_rst_busy", b_busy, 0);
    chk("mid_rst_valid", b_valid, 0);
    chk("mid_rst_done", b_done, 0);
    chk("mid_rst_rvalid", a0_rvalid, 0);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      seen = seen | b_valid | b_done;
    end
    chk("post_rst_quiet", seen, 0);
    acyc(1, 0, 0, 9, 0, 1, 0, 0, 10, 0);
    acyc(1, 0, 0, 11, 0, 1, 0, 0, 12, 0);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
